// File: rtl/baud_pkg.sv
// Shared types and elaboration-time helpers for the fractional baud NCO.
package baud_pkg;

  typedef enum logic [1:0] {
    OSR_16 = 2'd0,
    OSR_8  = 2'd1,
    OSR_4  = 2'd2,
    OSR_2  = 2'd3
  } osr_e;

  localparam int OS_CNT_W = 4;

  function automatic int unsigned osr_of(osr_e r);
    case (r)
      OSR_16:  return 16;
      OSR_8:   return 8;
      OSR_4:   return 4;
      default: return 2;
    endcase
  endfunction

  // floor(2^acc_w * osr * baud / freq); real has enough mantissa for acc_w <= 48.
  function automatic logic [63:0] calc_inc(int unsigned freq, int unsigned baud,
                                           int unsigned osr, int unsigned acc_w);
    real step;
    step = (2.0 ** acc_w) * real'(osr) * real'(baud) / real'(freq);
    return longint'($floor(step));
  endfunction

endpackage

// File: rtl/nco_accum.sv
// Phase accumulator for the baud NCO: ACC_W-bit accumulator, registered carry
// tick, synchronous clear. The remainder is kept on overflow so no phase is lost.
module nco_accum
#(
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             carry_o,
  output logic             tick_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_i};
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      {tick_d, acc_d} = sum;
    end
  end

  // Combinational carry of this cycle's add; the top uses it for os_cnt and config.
  assign carry_o = tick_d;
  assign tick_o  = tick_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/baud_nco_gen.sv
// Runtime-reconfigurable fractional baud tick generator: NCO accumulator plus
// oversample counter, bit tick, start-bit resync and bit-boundary config switch.
module baud_nco_gen
  import baud_pkg::*;
#(
  parameter int FREQ     = 100000000,
  parameter int BAUDRATE = 921600,
  parameter int ACC_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       rate_i,
  input  logic             inc_sel_i,
  input  logic             inc_wr_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             sync_i,
  output logic             os_tick_o,
  output logic             bit_tick_o,
  output logic [3:0]       os_cnt_o,
  output logic             cfg_ack_o
);

  typedef logic [ACC_W-1:0]    inc_t;
  typedef logic [OS_CNT_W-1:0] os_cnt_t;

  localparam logic [63:0] RAW_X16 = calc_inc(FREQ, BAUDRATE, osr_of(OSR_16), ACC_W);
  localparam logic [63:0] RAW_X8  = calc_inc(FREQ, BAUDRATE, osr_of(OSR_8),  ACC_W);
  localparam logic [63:0] RAW_X4  = calc_inc(FREQ, BAUDRATE, osr_of(OSR_4),  ACC_W);
  localparam logic [63:0] RAW_X2  = calc_inc(FREQ, BAUDRATE, osr_of(OSR_2),  ACC_W);

  localparam inc_t TBL_X16 = inc_t'(RAW_X16);
  localparam inc_t TBL_X8  = inc_t'(RAW_X8);
  localparam inc_t TBL_X4  = inc_t'(RAW_X4);
  localparam inc_t TBL_X2  = inc_t'(RAW_X2);

  if (ACC_W < 8 || ACC_W > 48) begin : g_chk_acc_w
    $error("baud_nco_gen: ACC_W=%0d outside 8..48", ACC_W);
  end
  if (16 * BAUDRATE >= FREQ) begin : g_chk_ratio
    $error("baud_nco_gen: 16*BAUDRATE must be below FREQ");
  end
  if (RAW_X16 == 64'd0 || RAW_X8 == 64'd0 || RAW_X4 == 64'd0 || RAW_X2 == 64'd0)
  begin : g_chk_table
    $error("baud_nco_gen: increment table has a zero entry, widen ACC_W");
  end

  function automatic inc_t table_inc(osr_e r);
    case (r)
      OSR_16:  return TBL_X16;
      OSR_8:   return TBL_X8;
      OSR_4:   return TBL_X4;
      default: return TBL_X2;
    endcase
  endfunction

  // Active configuration and the staged copy waiting for a bit boundary.
  osr_e    act_rate_q, act_rate_d;
  logic    act_sel_q,  act_sel_d;
  inc_t    shadow_q,   shadow_d;
  inc_t    stage_q,    stage_d;
  logic    pend_q,     pend_d;
  logic    ack_q,      ack_d;
  logic    bit_tick_q, bit_tick_d;
  os_cnt_t os_cnt_q,   os_cnt_d;

  osr_e    rate_req;
  inc_t    inc_a;
  os_cnt_t osr_last;
  os_cnt_t osr_half;
  logic    carry;
  logic    sync_hit;
  logic    bit_carry;
  logic    new_req;
  logic    apply;
  logic    acc_clr;

  assign rate_req = osr_e'(rate_i);
  assign osr_last = os_cnt_t'(osr_of(act_rate_q) - 1);
  assign osr_half = os_cnt_t'(osr_of(act_rate_q) >> 1);
  assign inc_a    = act_sel_q ? shadow_q : table_inc(act_rate_q);

  // Resync and disable both restart the phase from zero.
  assign sync_hit = en_i & sync_i;
  assign acc_clr  = ~en_i | sync_i;

  nco_accum #(
    .ACC_W (ACC_W)
  ) u_accum (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .clr_i   (acc_clr),
    .inc_i   (inc_a),
    .carry_o (carry),
    .tick_o  (os_tick_o)
  );

  assign bit_carry = carry & (os_cnt_q == osr_last);
  assign new_req   = (rate_req != act_rate_q) | (inc_sel_i != act_sel_q) | inc_wr_i;

  // A change is folded in on the cycle it is seen, so an idle generator acks next cycle.
  assign apply = (pend_q | new_req) & ~sync_hit & (~en_i | bit_carry);

  always_comb begin
    stage_d    = inc_wr_i ? inc_i : stage_q;
    pend_d     = (pend_q | new_req) & ~apply;
    act_rate_d = act_rate_q;
    act_sel_d  = act_sel_q;
    shadow_d   = shadow_q;
    ack_d      = apply;
    bit_tick_d = bit_carry;
    os_cnt_d   = os_cnt_q;

    if (apply) begin
      act_rate_d = rate_req;
      act_sel_d  = inc_sel_i;
      shadow_d   = stage_d;
    end

    if (!en_i) begin
      os_cnt_d = '0;
    end else if (sync_hit) begin
      os_cnt_d = osr_half;
    end else if (apply && (rate_req != act_rate_q)) begin
      os_cnt_d = '0;
    end else if (carry) begin
      os_cnt_d = bit_carry ? os_cnt_t'(0) : os_cnt_q + os_cnt_t'(1);
    end
  end

  // Staging starts equal to the shadow so a rate-only change reloads the same value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_rate_q <= OSR_16;
      act_sel_q  <= 1'b0;
      shadow_q   <= TBL_X16;
      stage_q    <= TBL_X16;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      bit_tick_q <= 1'b0;
      os_cnt_q   <= '0;
    end else begin
      act_rate_q <= act_rate_d;
      act_sel_q  <= act_sel_d;
      shadow_q   <= shadow_d;
      stage_q    <= stage_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      bit_tick_q <= bit_tick_d;
      os_cnt_q   <= os_cnt_d;
    end
  end

  assign bit_tick_o = bit_tick_q;
  assign os_cnt_o   = os_cnt_q;
  assign cfg_ack_o  = ack_q;

endmodule

// File: tb/tb_baud_nco_gen.sv
// Directed bench for baud_nco_gen: a default 32-bit instance and an 8-bit instance.
module tb_baud_nco_gen;

  localparam longint INC16_32 = 633318697;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en32 = 1'b0, sel32 = 1'b0, wr32 = 1'b0, sync32 = 1'b0;
  logic [1:0] rate32 = 2'd0;
  logic [31:0] inc32 = '0;
  logic       os32, bit32, ack32;
  logic [3:0] cnt32;

  logic       en8 = 1'b0, sel8 = 1'b0, wr8 = 1'b0, sync8 = 1'b0;
  logic [1:0] rate8 = 2'd0;
  logic [7:0] inc8 = '0;
  logic       os8, bit8, ack8;
  logic [3:0] cnt8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] rate;
    logic       sel;
    logic [7:0] inc;
    int         n;
    int         exp_os;
    int         exp_bit;
    int         exp_first_os;
    int         exp_first_bit;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  baud_nco_gen u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en32), .rate_i(rate32), .inc_sel_i(sel32),
    .inc_wr_i(wr32), .inc_i(inc32), .sync_i(sync32), .os_tick_o(os32),
    .bit_tick_o(bit32), .os_cnt_o(cnt32), .cfg_ack_o(ack32)
  );

  baud_nco_gen #(.ACC_W(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .rate_i(rate8), .inc_sel_i(sel8),
    .inc_wr_i(wr8), .inc_i(inc8), .sync_i(sync8), .os_tick_o(os8),
    .bit_tick_o(bit8), .os_cnt_o(cnt8), .cfg_ack_o(ack8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [63:0] act,
                           input logic [63:0] lo, input logic [63:0] hi);
    checks++;
    if ($isunknown(act) || act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Program the 8-bit instance while disabled; the ack must follow one cycle later.
  task automatic cfg8(input logic [1:0] r, input logic s, input logic [7:0] v, input string tag);
    @(negedge clk);
    rate8 = r; sel8 = s; inc8 = v; wr8 = 1'b1;
    @(negedge clk);
    wr8 = 1'b0;
    check({tag, " ack"}, 64'(ack8), 64'd1);
    @(negedge clk);
    check({tag, " ack single"}, 64'(ack8), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nos = 0, nbit = 0, f_os = 0, f_bit = 0, bad = 0, nack = 0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    cfg8(v.rate, v.sel, v.inc, tag);
    en8 = 1'b1;
    for (int c = 1; c <= v.n; c++) begin
      @(negedge clk);
      if (os8) begin nos++; if (f_os == 0) f_os = c; end
      if (bit8) begin
        nbit++;
        if (f_bit == 0) f_bit = c;
        if (!os8 || cnt8 != 4'd0) bad++;
      end
      if (ack8) nack++;
    end
    en8 = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, 64'({os8, bit8, cnt8}), 64'd0);
    check({tag, " os ticks"}, 64'(nos), 64'(v.exp_os));
    check({tag, " bit ticks"}, 64'(nbit), 64'(v.exp_bit));
    check({tag, " first os"}, 64'(f_os), 64'(v.exp_first_os));
    check({tag, " first bit"}, 64'(f_bit), 64'(v.exp_first_bit));
    check({tag, " bit coherence"}, 64'(bad), 64'd0);
    check({tag, " no ack"}, 64'(nack), 64'd0);
  endtask

  // Defaults on the 32-bit instance: x16 table increment, short window.
  task automatic test_default();
    int nos = 0, nbit = 0, f_os = 0, last = 0, bad_sp = 0, last_b = 0, bad_bsp = 0, nack = 0;
    longint exp_os;
    localparam int N = 20000;
    exp_os = (longint'(N) * INC16_32) >>> 32;
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      if (os32) begin
        nos++;
        if (f_os == 0) f_os = c;
        if (last != 0 && (c - last < 6 || c - last > 7)) bad_sp++;
        last = c;
      end
      if (bit32) begin
        nbit++;
        if (last_b != 0 && (c - last_b < 108 || c - last_b > 109)) bad_bsp++;
        last_b = c;
      end
      if (ack32) nack++;
    end
    check("def os ticks", 64'(nos), 64'(exp_os));
    check("def bit ticks", 64'(nbit), 64'(exp_os / 16));
    check("def first os", 64'(f_os), 64'd7);
    check("def os spacing", 64'(bad_sp), 64'd0);
    check("def bit spacing", 64'(bad_bsp), 64'd0);
    check("def no ack", 64'(nack), 64'd0);
  endtask

  // Rate 0 -> 3 while running: switch lands on a bit tick, os_cnt restarts.
  task automatic test_rate();
    int bits_q[$];
    int ack_t = 0, nack = 0, cnt_bad = 0, bad_sp = 0;
    rate32 = 2'd3;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      if (bit32) bits_q.push_back(c);
      if (ack32) begin
        nack++;
        if (ack_t == 0) begin
          ack_t = c;
          check("rate cnt cleared", 64'(cnt32), 64'd0);
        end
      end
      if (ack_t != 0 && c > ack_t && cnt32 > 4'd1) cnt_bad++;
    end
    check("rate ack count", 64'(nack), 64'd1);
    if (bits_q.size() < 4) begin
      check("rate bit tick count", 64'(bits_q.size()), 64'd4);
    end else begin
      check("rate ack on bit tick", 64'(ack_t), 64'(bits_q[0]));
      check_rng("rate crossing spacing", 64'(bits_q[1] - bits_q[0]), 64'd100, 64'd110);
      for (int i = 2; i < bits_q.size(); i++)
        if (bits_q[i] - bits_q[i-1] < 108 || bits_q[i] - bits_q[i-1] > 109) bad_sp++;
      check("rate x2 bit spacing", 64'(bad_sp), 64'd0);
    end
    check("rate cnt range x2", 64'(cnt_bad), 64'd0);
    en32 = 1'b0;
    rate32 = 2'd0;
  endtask

  // Write inc=32 at os_cnt=5; the period changes only after the next bit tick.
  task automatic test_midstream();
    int q[$];
    int ack_t = 0, bit_t = 0, nack = 0, early = 0;
    logic found = 1'b0;
    cfg8(2'd0, 1'b1, 8'd64, "mid cfg");
    en8 = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (cnt8 == 4'd5) found = 1'b1;
    end
    check("mid reach cnt5", 64'(found), 64'd1);
    inc8 = 8'd32; wr8 = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      wr8 = 1'b0;
      if (os8) begin q.push_back(c); if (c <= 44) early++; end
      if (bit8 && bit_t == 0) bit_t = c;
      if (ack8) begin nack++; if (ack_t == 0) ack_t = c; end
    end
    check("mid ticks at period 4", 64'(early), 64'd11);
    check("mid bit tick", 64'(bit_t), 64'd44);
    check("mid ack", 64'(ack_t), 64'd44);
    check("mid ack count", 64'(nack), 64'd1);
    if (q.size() >= 13) begin
      check("mid new tick 1", 64'(q[11]), 64'd52);
      check("mid new tick 2", 64'(q[12]), 64'd60);
    end else begin
      check("mid tick count", 64'(q.size()), 64'd13);
    end
    en8 = 1'b0;
  endtask

  // sync_i coincident with a carry: tick suppressed, os_cnt=8, bit tick 32 cycles later.
  task automatic test_sync();
    int f_os = 0, f_bit = 0, s_bit = 0, nos = 0;
    logic found = 1'b0;
    cfg8(2'd0, 1'b1, 8'd64, "sync cfg");
    en8 = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (os8) found = 1'b1;
    end
    check("sync found tick", 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    sync8 = 1'b1;
    @(negedge clk);
    sync8 = 1'b0;
    check("sync no tick", 64'({os8, bit8}), 64'd0);
    check("sync os_cnt", 64'(cnt8), 64'd8);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (os8) begin nos++; if (f_os == 0) f_os = c; end
      if (bit8) begin
        if (f_bit == 0) f_bit = c;
        else if (s_bit == 0) s_bit = c;
      end
    end
    check("sync first os", 64'(f_os), 64'd4);
    check("sync os count", 64'(nos), 64'd25);
    check("sync first bit", 64'(f_bit), 64'd32);
    check("sync second bit", 64'(s_bit), 64'd96);
    en8 = 1'b0;
  endtask

  // Asynchronous reset with a staged write pending; table x16 afterwards, no ack.
  task automatic test_reset();
    int nos = 0, f_os = 0, nack = 0;
    cfg8(2'd0, 1'b1, 8'd64, "rst cfg");
    en8 = 1'b1;
    repeat (22) @(negedge clk);
    inc8 = 8'd32; wr8 = 1'b1;
    @(negedge clk);
    wr8 = 1'b0;
    @(posedge clk);
    #2;
    check_rng("rst pre cnt", 64'(cnt8), 64'd1, 64'd15);
    rst_n = 1'b0;
    #1;
    check("rst async outputs", 64'({os8, bit8, cnt8, ack8}), 64'd0);
    en8 = 1'b0; sel8 = 1'b0; rate8 = 2'd0; inc8 = '0;
    @(negedge clk);
    check("rst held outputs", 64'({os8, bit8, cnt8, ack8}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en8 = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (os8) begin nos++; if (f_os == 0) f_os = c; end
      if (ack8) nack++;
    end
    check("rst table os ticks", 64'(nos), 64'd37);
    check("rst table first os", 64'(f_os), 64'd7);
    check("rst no ack", 64'(nack), 64'd0);
    en8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rate, sel, inc, cycles, os, bit, first os, first bit (ACC_W=8)
    vecs[0] = '{2'd0, 1'b1, 8'd64,  256, 64, 4,  4,  64};
    vecs[1] = '{2'd1, 1'b1, 8'd128, 64,  32, 4,  2,  16};
    vecs[2] = '{2'd2, 1'b1, 8'd255, 64,  63, 15, 2,  5};
    vecs[3] = '{2'd3, 1'b0, 8'd9,   256, 4,  2,  64, 128};
    vecs[4] = '{2'd0, 1'b0, 8'd9,   256, 37, 2,  7,  111};
    vecs[5] = '{2'd0, 1'b1, 8'd0,   100, 0,  0,  0,  0};

    repeat (3) @(negedge clk);
    en32 = 1'b1;
    @(negedge clk);
    check("reset dut32 outputs", 64'({os32, bit32, cnt32, ack32}), 64'd0);
    check("reset dut8 outputs", 64'({os8, bit8, cnt8, ack8}), 64'd0);
    rst_n = 1'b1;

    test_default();
    test_rate();
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    test_midstream();
    test_sync();
    test_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_nco_gen.md
Name: baud_nco_gen

Overview:
- Parametrised, runtime-reconfigurable fractional baud tick generator (NCO phase accumulator).
- Successor to the fixed-table UART tick generator. Adds:
  - selectable accumulator width;
  - a software-programmable increment;
  - glitch-free configuration changes at bit boundaries;
  - a bit-rate tick derived from the oversampled tick;
  - start-bit resynchronisation for RX centring.
- Sits between UART config registers and the rx/tx engines.

Parameters:
- FREQ, 100000000: system clock frequency in Hz.
- BAUDRATE, 921600: nominal baud rate used for the built-in increment table.
- ACC_W, 32: phase accumulator width in bits, 8..48.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: asynchronous active-low reset.
- en_i, input, 1: generator enable; low = idle.
- rate_i, input, 2: oversampling select; 0=x16, 1=x8, 2=x4, 3=x2.
- inc_sel_i, input, 1: increment source; 0=built-in table, 1=programmed register.
- inc_wr_i, input, 1: one-cycle strobe that loads inc_i into the shadow register.
- inc_i, input, ACC_W: programmed increment value.
- sync_i, input, 1: one-cycle pulse from a start-bit edge; restarts bit phase.
- os_tick_o, output, 1: oversampled tick, one-cycle pulse.
- bit_tick_o, output, 1: bit-rate tick, one-cycle pulse, coincident with an os_tick_o.
- os_cnt_o, output, 4: current oversample index, 0..OSR-1.
- cfg_ack_o, output, 1: one-cycle pulse when a pending configuration becomes active.

Behaviour:
- Reset (async, rst_ni=0):
  - all outputs 0;
  - acc=0, os_cnt=0;
  - active rate=x16, active inc_sel=0;
  - shadow increment = TABLE[x16];
  - no configuration pending.
- Table entries: TABLE[r] = floor(2^ACC_W * OSR(r) * BAUDRATE / FREQ), computed at elaboration in real arithmetic.
  - Elaboration $error if 16*BAUDRATE >= FREQ, or if any table entry is 0.
- Active increment: inc_a = TABLE[active rate] when active inc_sel=0, else the shadow register.
- Accumulator: acc is ACC_W bits; the adder is ACC_W+1 bits.
  - When en_i=1 each cycle: {carry, acc} <= acc + inc_a.
  - The remainder is kept, so there is no phase loss on overflow.
- os_tick_o is registered: it is high in cycle N+1 iff the add in cycle N carried.
- os_cnt advances on each carry.
  - When os_cnt == OSR-1 at a carry, it wraps to 0 and bit_tick_o is high in the same cycle as that os_tick_o.
- Configuration pending flag: set when any of the following is seen:
  - rate_i != active rate;
  - inc_sel_i != active inc_sel;
  - inc_wr_i=1, which also loads inc_i into a staging register.
- Pending configuration is applied:
  - on the cycle a bit-boundary carry occurs (new increment used from the next cycle); or
  - immediately while en_i=0.
- cfg_ack_o pulses for one cycle in the cycle after application.
- A new inc_wr_i while a configuration is pending overwrites the staging value; the last write wins, giving one ack only.
- If rate_i changes while pending, the latest rate_i is sampled at application time.
- When the rate changes, os_cnt is cleared to 0 at application.
- sync_i has the highest priority over carry and over config application in the same cycle:
  - acc <= 0 and os_cnt <= OSR/2;
  - no tick is issued in that cycle;
  - the first bit_tick_o follows after OSR/2 os ticks (mid start bit), then every OSR ticks.
- en_i=0:
  - acc and os_cnt are held at 0;
  - ticks are suppressed;
  - sync_i is ignored.
- On en_i rising, the first carry occurs after ceil(2^ACC_W / inc_a) cycles.
- A programmed increment of 0 is legal: no ticks, and pending config is never applied unless en_i=0.
  - Software must disable the generator to recover.
- Reset mid-operation: immediate return to reset values, and any pending configuration is discarded.

Decomposition:
- Package baud_pkg holds:
  - osr_e enum (OSR_16, OSR_8, OSR_4, OSR_2);
  - function osr_of(osr_e), returning 16/8/4/2;
  - function calc_inc(freq, baud, osr, acc_w).
- Sub-module nco_accum: ACC_W accumulator, carry register, synchronous clear.
- Top level holds the os counter, config staging, pending/apply logic and ack.

Test Plan:
- Defaults, x16, 10^6 cycles after reset release:
  - TABLE[x16] = 633318697;
  - 147456 ±1 os ticks;
  - 9216 ±1 bit ticks;
  - os tick spacing only 6 or 7 cycles.
- ACC_W=8, inc_sel=1, inc_i=64 written while en_i=0:
  - cfg_ack_o pulses the next cycle;
  - after enabling, os_tick_o every 4 cycles exactly;
  - bit_tick_o every 64 cycles, on the os tick where os_cnt_o wraps from 15.
- Mid-stream, write inc_i=32 at os_cnt=5:
  - period stays 4 until the next bit_tick_o;
  - cfg_ack_o fires the cycle after;
  - period then becomes 8.
- With inc=64, assert sync_i on the same cycle as a carry:
  - no tick that cycle;
  - os_cnt_o=8;
  - first bit_tick_o exactly 32 cycles later, then every 64.
- Change rate_i 0->3 with inc_sel=0:
  - active rate switches only at a bit boundary, os_cnt_o cleared, ack pulse;
  - bit-tick spacing is preserved to ±1 cycle.
- Deassert rst_ni asynchronously, mid-pending config, between clock edges:
  - all outputs 0 immediately;
  - after release, the x16 table rate runs with no ack.
